// File: rtl/rv32i_dbg_port.sv
// rv32i_dbg_port
// Debug responder for the RV32I pipeline. An external host sends commands
// on a valid/ready channel. The block halts the core, then performs a
// byte-serial access on data or instruction memory, a single register-file
// access, or a PC read. It returns exactly one response per command.
//
// Ports
//   clock, reset_n                 single clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op/addr/size/data          command fields
//   rsp_valid/rsp_ready            response handshake
//   rsp_data/rsp_err               read result (zero-extended) and error flag
//   halt_req/halt_ack              core stall request and acknowledge
//   dmem_*/imem_*                  byte-wide memory ports, synchronous read
//   rf_*                           register-file port, combinational read
//   pc                             core fetch PC
//
// Build option
//   DBG_BOUNDS_CHECK_EN  when defined, rejects memory accesses that run past
//                        the top of memory or carry non-zero upper address
//                        bits, and register accesses with index bits above [4:0].
module rv32i_dbg_port #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [XLEN-1:0]       cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [XLEN-1:0]       cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_err,
  output logic                  halt_req,
  input  logic                  halt_ack,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic                  dmem_we,
  output logic [7:0]            dmem_wdata,
  input  logic [7:0]            dmem_rdata,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_we,
  output logic [7:0]            imem_wdata,
  input  logic [7:0]            imem_rdata,
  output logic [4:0]            rf_addr,
  output logic                  rf_we,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [XLEN-1:0]       rf_rdata,
  input  logic [XLEN-1:0]       pc
);

  // state  | meaning
  // IDLE   | no command; waiting for cmd_valid
  // HALT   | halt requested; accept command once the core acknowledges
  // MEM    | byte-serial memory access, one byte per cycle
  // CAP    | capture the last read byte (memory read latency is one cycle)
  // REG    | single register-file read or write
  // RESP   | hold response until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_MEM, S_CAP, S_REG, S_RESP
  } state_t;

  localparam logic [2:0] OP_RD_PC = 3'd6;
  localparam logic [2:0] OP_ILL   = 3'd7;

  state_t                r_state;
  logic                  r_write;
  logic                  r_imem;
  logic [1:0]            r_last;
  logic [1:0]            r_cnt;
  logic [XLEN-1:0]       r_data;
  logic [ADDR_WIDTH-1:0] r_maddr;
  logic [7:0]            r_mwdata;
  logic                  r_mwe;
  logic [4:0]            r_rf_addr;
  logic                  r_rf_we;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_rsp_valid;
  logic [XLEN-1:0]       r_rsp_data;
  logic                  r_rsp_err;
  logic                  r_halt_req;

  logic [1:0] w_last;
  logic [1:0] w_prev_cnt;
  logic [1:0] w_next_cnt;
  logic       w_is_mem;
  logic       w_is_reg;
  logic       w_mem_oob;
  logic       w_reg_oob;
  logic       w_err;
  logic [7:0] w_rdata;
  logic       w_unused;

  always_comb begin
    case (cmd_size)
      2'd0:    w_last = 2'd0;
      2'd1:    w_last = 2'd1;
      default: w_last = 2'd3;
    endcase
  end

  assign w_is_mem = ~cmd_op[2];
  assign w_is_reg = (cmd_op == 3'd4) || (cmd_op == 3'd5);

`ifdef DBG_BOUNDS_CHECK_EN
  logic [ADDR_WIDTH:0] w_mem_end;
  // Carry out of the last byte address means the access runs off the top.
  assign w_mem_end = {1'b0, cmd_addr[ADDR_WIDTH-1:0]} + {{(ADDR_WIDTH-1){1'b0}}, w_last};
  assign w_mem_oob = (|cmd_addr[XLEN-1:ADDR_WIDTH]) | w_mem_end[ADDR_WIDTH];
  assign w_reg_oob = |cmd_addr[XLEN-1:5];
`else
  assign w_mem_oob = 1'b0;
  assign w_reg_oob = 1'b0;
`endif

  // Upper address bits are only consumed by the bounds check.
  assign w_unused = &{1'b0, cmd_addr[XLEN-1:ADDR_WIDTH]};

  assign w_err = (cmd_op == OP_ILL) | (cmd_size == 2'd3) |
                 (w_is_mem & w_mem_oob) | (w_is_reg & w_reg_oob);

  assign w_prev_cnt = r_cnt - 2'd1;
  assign w_next_cnt = r_cnt + 2'd1;
  assign w_rdata    = r_imem ? imem_rdata : dmem_rdata;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_imem      <= 1'b0;
      r_last      <= 2'd0;
      r_cnt       <= 2'd0;
      r_data      <= '0;
      r_maddr     <= '0;
      r_mwdata    <= '0;
      r_mwe       <= 1'b0;
      r_rf_addr   <= '0;
      r_rf_we     <= 1'b0;
      r_rf_wdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_halt_req  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_halt_req <= 1'b1;
            r_state    <= S_HALT;
          end
        end

        S_HALT: begin
          if (cmd_valid && halt_ack) begin
            r_write    <= cmd_op[0];
            r_imem     <= cmd_op[1];
            r_last     <= w_last;
            r_cnt      <= 2'd0;
            r_data     <= cmd_data;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            if (w_err) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (cmd_op == OP_RD_PC) begin
              r_rsp_data  <= pc;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (cmd_op[2]) begin
              r_rf_addr  <= cmd_addr[4:0];
              // x0 is hardwired; a write to it is dropped silently.
              r_rf_we    <= cmd_op[0] & (|cmd_addr[4:0]);
              r_rf_wdata <= cmd_data;
              r_state    <= S_REG;
            end else begin
              r_maddr  <= cmd_addr[ADDR_WIDTH-1:0];
              r_mwe    <= cmd_op[0];
              r_mwdata <= cmd_data[7:0];
              r_state  <= S_MEM;
            end
          end
        end

        S_MEM: begin
          // Read data arrives one cycle after its address: byte i-1 now.
          if (!r_write && (r_cnt != 2'd0))
            r_rsp_data[{w_prev_cnt, 3'b000} +: 8] <= w_rdata;
          if (r_cnt == r_last) begin
            r_mwe <= 1'b0;
            if (r_write) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_CAP;
            end
          end else begin
            r_cnt    <= w_next_cnt;
            r_maddr  <= r_maddr + ADDR_WIDTH'(1);
            r_mwdata <= r_data[{w_next_cnt, 3'b000} +: 8];
          end
        end

        S_CAP: begin
          r_rsp_data[{r_last, 3'b000} +: 8] <= w_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_REG: begin
          r_rf_we <= 1'b0;
          if (!r_write)
            r_rsp_data <= rf_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_halt_req  <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_HALT) & halt_ack;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign halt_req   = r_halt_req;
  assign dmem_addr  = r_maddr;
  assign dmem_we    = r_mwe & ~r_imem;
  assign dmem_wdata = r_mwdata;
  assign imem_addr  = r_maddr;
  assign imem_we    = r_mwe & r_imem;
  assign imem_wdata = r_mwdata;
  assign rf_addr    = r_rf_addr;
  assign rf_we      = r_rf_we;
  assign rf_wdata   = r_rf_wdata;

endmodule

// File: doc/rv32i_dbg_port.md
# rv32i_dbg_port

Hardware debug responder for the RV32I pipeline: the in-silicon counterpart of the simulation backdoor that reads and writes data memory, instruction memory, register file and PC. An external host issues commands on a valid/ready channel. The block halts the core, performs byte-serial accesses on the byte-wide memories or single accesses on the register file, and returns one response per command. It sits beside `rv32i_pipe`, muxed onto the memory and register-file write/read ports while the core is halted.

## Interface
- `XLEN`, 32, data width of commands, responses and registers
- `ADDR_WIDTH`, 16, byte-address width of each memory; memory depth is 2**ADDR_WIDTH bytes
- `clock` in 1 — single clock
- `reset_n` in 1 — synchronous, active-low reset
- `cmd_valid` in 1 / `cmd_ready` out 1 — command handshake
- `cmd_op` in 3 — 0 RD_DMEM, 1 WR_DMEM, 2 RD_IMEM, 3 WR_IMEM, 4 RD_REG, 5 WR_REG, 6 RD_PC, 7 illegal
- `cmd_addr` in XLEN — byte address, or register index in [4:0]
- `cmd_size` in 2 — 0 selects 1 byte, 1 selects 2 bytes, 2 selects 4 bytes, 3 is illegal
- `cmd_data` in XLEN — write data, little-endian
- `rsp_valid` out 1 / `rsp_ready` in 1 — response handshake
- `rsp_data` out XLEN / `rsp_err` out 1 — read result and error flag
- `halt_req` out 1 / `halt_ack` in 1 — core stall request and acknowledge
- `dmem_addr` out ADDR_WIDTH, `dmem_we` out 1, `dmem_wdata` out 8, `dmem_rdata` in 8 — data-memory port, synchronous read
- `imem_addr` out ADDR_WIDTH, `imem_we` out 1, `imem_wdata` out 8, `imem_rdata` in 8 — instruction-memory port, same rules
- `rf_addr` out 5, `rf_we` out 1, `rf_wdata` out XLEN, `rf_rdata` in XLEN — register-file port, combinational read
- `pc` in XLEN — the core's fetch PC

## Operation
- States: IDLE, HALT, MEM, CAP, REG, RESP.
- IDLE: when `cmd_valid` is high, assert `halt_req` and go to HALT.
- HALT: `cmd_ready` = `halt_ack`. On handshake, latch all cmd fields and branch:
  - illegal op or size: RESP with `rsp_err`=1 and `rsp_data`=0.
  - RD_PC: latch `pc` and go to RESP.
  - RD_REG / WR_REG: go to REG.
  - memory ops: go to MEM.
- MEM: a 2-bit byte counter i runs from 0 to n-1.
  - Address is `addr+i`, truncated to ADDR_WIDTH (wraps).
  - Writes drive byte i of `cmd_data` with `we`=1.
  - Reads capture byte i of the previous cycle into `rsp_data[8i+7:8i]`.
  - After byte n-1: reads go to CAP, which captures the final byte and goes to RESP; writes go directly to RESP.
- Read results are zero-extended; unused upper bytes are 0.
- REG: drive `rf_addr`.
  - WR_REG pulses `rf_we` unless the index is 0; a write to x0 is silently dropped with no error.
  - RD_REG latches `rf_rdata`.
  - Then go to RESP.
- RESP: `rsp_valid`=1 and all rsp fields held stable until `rsp_ready`. Then deassert `halt_req` and return to IDLE.
- `halt_req` stays high from the first `cmd_valid` until the response handshake. Back-to-back commands re-request the halt.
- Reset values: `cmd_ready`, `rsp_valid`, `rsp_err`, `halt_req`, all `we` = 0; `rsp_data` and all address/wdata outputs = 0; state = IDLE.
- Reset mid-operation: abort immediately, return to IDLE, release the halt. Bytes already written are not rolled back.

## Timing
- T is the command-accept cycle.
- RD_PC: `rsp_valid` at T+1.
- RD_REG / WR_REG: `rsp_valid` at T+2.
- Memory write of n bytes: `we` high at T+1..T+n; `rsp_valid` at T+n+1.
- Memory read of n bytes: addresses at T+1..T+n; `rsp_valid` at T+n+2.
- Illegal op or size: `rsp_valid` at T+1 with no port activity.
- `rsp_valid` never depends combinationally on `rsp_ready`; `cmd_ready` depends only on state and `halt_ack`.
- `we` outputs are never high outside MEM or REG.

## Configuration
- `DBG_BOUNDS_CHECK_EN` defined:
  - A memory access with `cmd_addr + n - 1 >= 2**ADDR_WIDTH`, or non-zero `cmd_addr[XLEN-1:ADDR_WIDTH]`, is rejected with `rsp_err`=1, `rsp_data`=0, `rsp_valid` at T+1 and no writes.
  - A register access with `cmd_addr[XLEN-1:5]` non-zero is rejected the same way.
- Undefined: upper address bits are ignored and addresses wrap modulo 2**ADDR_WIDTH. Only illegal op or size sets `rsp_err`.

## Test plan
- WR_DMEM addr 0x10, size 2, data 0x0000BEEF, then RD_DMEM same → dmem[0x10]=0xEF, dmem[0x11]=0xBE; rsp_data=0x0000BEEF, rsp_err=0; write response at T+3, read response at T+4.
- WR_IMEM 0x100, size 4, 0x00500093, then RD_IMEM → 0x00500093; 4 consecutive imem_we pulses.
- WR_REG x5=0xDEADBEEF then RD_REG x5 → 0xDEADBEEF; WR_REG x0=1 → no rf_we pulse, rsp_err=0.
- RD_PC with pc=0x80 → rsp_data=0x80 at T+1; halt_ack held low for 5 cycles → cmd_ready stays 0 and halt_req stays 1 throughout.
- cmd_op=7, or cmd_size=3 → rsp_err=1, rsp_data=0, no we activity; with `DBG_BOUNDS_CHECK_EN`, RD_DMEM at 0xFFFF size 4 → rsp_err=1; without it the read wraps to bytes 0xFFFF,0x0,0x1,0x2.
- reset_n low during the 3rd byte of a 4-byte write → next cycle all outputs 0, state IDLE; a subsequent RD_PC completes normally.
